memop_sequencer: RTL

MEMOP_SEQUENCER -- requirements
Module: memop_sequencer

---
 rtl/memop_sequencer_pkg.sv | 23 ++
 rtl/memop_alu.sv | 40 ++++
 rtl/memop_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/memop_sequencer_pkg.sv
// Shared types for the memory-operation sequencer and its ALU.
// Optional FFT support is selected with the SEQ_FFT_EN macro.
package memop_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      CALC,
      WR0,
      WR1,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      ENCR,
      DECR,
      FFT
   } mode_e;

   localparam int ROT_DEF = 3;

endpackage

// File: rtl/memop_alu.sv
// Combinational data transform: rotate-cipher and add/sub butterfly.
module memop_alu
   import memop_sequencer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ROT    = ROT_DEF
) (
   input  mode_e             mode_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] key_i,
   output logic [DATA_W-1:0] r0_o,
   output logic [DATA_W-1:0] r1_o
);

   localparam int R = ROT % DATA_W;

   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x);
      return (x << R) | (x >> (DATA_W - R));
   endfunction

   function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x);
      return (x >> R) | (x << (DATA_W - R));
   endfunction

   always_comb begin
      r0_o = '0;
      r1_o = '0;
      case (mode_i)
         ENCR: r0_o = rotl(a_i ^ key_i);
         DECR: r0_o = rotr(a_i) ^ key_i;
         FFT: begin
            r0_o = a_i + b_i;
            r1_o = a_i - b_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/memop_sequencer.sv
// Block memory-operation sequencer (encrypt/decrypt, optional FFT pairs).
// Define SEQ_FFT_EN to enable butterfly mode; otherwise fft_en is an error.
module memop_sequencer
   import memop_sequencer_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int ROT    = ROT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              encr_en,
   input  logic              decr_en,
   input  logic              fft_en,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        length,
   input  logic [DATA_W-1:0] key,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] res0, res1;
   logic [1:0]        n_en;
   logic              any_en, bad_en, adv;
   logic [7:0]        cnt_init;
   logic [ADDR_W-1:0] step;

   assign n_en   = 2'(encr_en) + 2'(decr_en) + 2'(fft_en);
   assign any_en = n_en != 2'd0;

`ifdef SEQ_FFT_EN
   logic [ADDR_W-1:0] addr_hi;
   assign addr_hi  = addr_q + ADDR_W'(1);
   assign bad_en   = n_en > 2'd1;
   // FFT counts pairs; a trailing odd word is skipped.
   assign cnt_init = fft_en ? (length >> 1) : length;
   assign step     = (mode_q == FFT) ? ADDR_W'(2) : ADDR_W'(1);
`else
   logic unused_res1;
   assign unused_res1 = ^res1;
   assign bad_en   = (n_en > 2'd1) | fft_en;
   assign cnt_init = length;
   assign step     = ADDR_W'(1);
`endif

   memop_alu #(
      .DATA_W(DATA_W),
      .ROT   (ROT)
   ) u_alu (
      .mode_i(mode_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .key_i (key_q),
      .r0_o  (res0),
      .r1_o  (res1)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      a_d     = a_q;
      b_d     = b_q;
      err_d   = err_q;
      adv     = 1'b0;
      case (state_q)
         IDLE: if (any_en) begin
            err_d   = bad_en;
            state_d = DONE;
            if (!bad_en) begin
               if (encr_en)      mode_d = ENCR;
               else if (decr_en) mode_d = DECR;
               else              mode_d = FFT;
               key_d  = key;
               addr_d = base_addr;
               cnt_d  = cnt_init;
               if (cnt_init != 8'd0) state_d = RD0;
            end
         end
         RD0: if (mem_ready) begin
            a_d = mem_rdata;
`ifdef SEQ_FFT_EN
            state_d = (mode_q == FFT) ? RD1 : CALC;
`else
            state_d = CALC;
`endif
         end
`ifdef SEQ_FFT_EN
         RD1: if (mem_ready) begin
            b_d     = mem_rdata;
            state_d = CALC;
         end
         WR1: if (mem_ready) adv = 1'b1;
`endif
         CALC: state_d = WR0;
         WR0: if (mem_ready) begin
`ifdef SEQ_FFT_EN
            if (mode_q == FFT) state_d = WR1;
            else               adv = 1'b1;
`else
            adv = 1'b1;
`endif
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (adv) begin
         if (cnt_q == 8'd1) begin
            state_d = DONE;
         end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_q + step;
            state_d = RD0;
         end
      end
   end

   always_comb begin
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_q)
         RD0: begin
            mem_rd_req = 1'b1;
            mem_addr   = addr_q;
         end
         WR0: begin
            mem_wr_req = 1'b1;
            mem_addr   = addr_q;
            mem_wdata  = res0;
         end
`ifdef SEQ_FFT_EN
         RD1: begin
            mem_rd_req = 1'b1;
            mem_addr   = addr_hi;
         end
         WR1: begin
            mem_wr_req = 1'b1;
            mem_addr   = addr_hi;
            mem_wdata  = res1;
         end
`endif
         default: ;
      endcase
   end

   assign busy  = (state_q != IDLE) && (state_q != DONE);
   assign stall = rst_n & ((state_q == IDLE && any_en) | busy);
   assign done  = state_q == DONE;
   assign err   = done & err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= ENCR;
         addr_q  <= '0;
         cnt_q   <= '0;
         key_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
      end
   end

endmodule
